bit_serial_adder: RTL and testbench
===================================

Name: bit_serial_adder

Overview:
- Sequential adder that adds two WIDTH-bit operands one bit per clock, LSB first.
- Uses a single 1-bit full-adder slice plus a registered carry.
- Sits downstream of the 1-bit full-adder cell: it reuses that slice across cycles and turns it into a multi-bit adder.
- Trades latency for area; used wherever a ripple-carry adder is too large.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      synchronous reset, active-high
- start  input   1      request; sampled only when the block is not busy
- a      input   WIDTH  operand A; captured on accepted start
- b      input   WIDTH  operand B; captured on accepted start
- cin    input   1      carry-in; captured on accepted start
- busy   output  1      high while bits are being processed
- done   output  1      one-cycle pulse: sum and cout are valid and newly updated
- sum    output  WIDTH  registered result; holds until the next completion
- cout   output  1      registered carry-out of the MSB; holds with sum

Behaviour:
- Reset (rst=1 at a rising edge):
  - state goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry register and bit counter all clear to 0.
  - Reset overrides start and any in-progress operation.
  - A reset during RUN aborts the operation: no done pulse, sum/cout forced to 0.
- States: IDLE, RUN, DONE (one cycle).
- IDLE:
  - On start=1, capture a and b into shift registers and cin into the carry register.
  - Clear the bit counter and go to RUN.
  - On start=0, stay in IDLE.
- RUN (busy=1):
  - Each edge computes bit_sum = a_sr[0] ^ b_sr[0] ^ carry.
  - Carry updates to majority(a_sr[0], b_sr[0], carry).
  - bit_sum shifts into the MSB of the accumulating shift register.
  - Operand registers shift right by one.
  - Counter increments.
  - start is ignored in RUN; no queuing and no effect on the current operation.
  - After the edge that processes bit WIDTH-1, transfer the accumulator to sum and the final carry to cout, then go to DONE.
- DONE:
  - done=1, busy=0 for exactly one cycle.
  - start=1 in DONE is accepted: operands are captured as in IDLE and the next state is RUN, so back-to-back operation is supported.
  - Otherwise go to IDLE.
- Latency:
  - start is sampled at edge E0; bits are processed at edges E1..E_WIDTH.
  - done is high in the cycle following E_WIDTH.
  - Start-to-done is WIDTH+1 edges; accepted-start-to-next-accepted-start throughput is WIDTH+1 cycles.
- Arithmetic:
  - {cout,sum} = a + b + cin, unsigned, exact (WIDTH+1 bits).
  - There is no overflow flag; cout is the overflow.
- Output stability:
  - sum and cout change only on the edge entering DONE, or on reset.
  - They are stable through subsequent RUN cycles.
- Counter is sized to count 0..WIDTH-1 with no wrap beyond WIDTH-1.
- Operand inputs a, b, cin may change freely after the accepted start edge.

Test Plan:
- Reset, then WIDTH=8, a=0x3C, b=0x5A, cin=0, start pulse:
  - busy high for 8 cycles.
  - done high exactly 9 edges after start.
  - sum=0x96, cout=0.
- Boundary carry, a=0xFF, b=0x01, cin=0:
  - sum=0x00, cout=1.
  - Then a=0xFF, b=0xFF, cin=1: sum=0xFF, cout=1.
- Start held high continuously with a=0x01, b=0x02, then operands changed to 0x10/0x20 during RUN:
  - first result sum=0x03.
  - Second operation starts from the DONE cycle; its result is sum=0x30.
  - No start is accepted mid-RUN.
- Reset asserted at RUN bit 4 of an op with a=0xAA, b=0x55:
  - next cycle busy=0, done=0, sum=0, cout=0.
  - done is never pulsed for the aborted op.
  - A fresh start with a=0x0F, b=0x0F then gives sum=0x1E, cout=0.
- Exhaustive WIDTH=2 (a, b, cin over all 32 combinations), each checked against a+b+cin:
  - all match.
  - sum/cout hold their value between done pulses.

Source files
------------

// File: rtl/bit_serial_adder_if.sv
// Request/result bundle for the bit-serial adder: operands and start in,
// busy/done status and the registered result out.
interface bit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/bit_serial_adder.sv
// Multi-bit adder built from one full-adder slice reused over WIDTH clocks,
// LSB first, with a registered carry between bit positions.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  bit_serial_adder_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CNT_W-1:0] cnt;
  logic             bit_sum;
  logic             bit_carry;
  logic             last_bit;
  logic             accept;

  assign bit_sum   = a_sr[0] ^ b_sr[0] ^ carry;
  assign bit_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
  // DONE accepts a new request just like IDLE, so back-to-back ops lose no cycle
  assign accept    = bus.start && (state != RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      RUN:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // The counter parks at WIDTH-1 after the final bit instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sr  <= bus.a;
      b_sr  <= bus.b;
      carry <= bus.cin;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      carry <= bit_carry;
      acc   <= {bit_sum, acc[WIDTH-1:1]};
      if (last_bit) begin
        sum_q  <= {bit_sum, acc[WIDTH-1:1]};
        cout_q <= bit_carry;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench: stimulus pushes expected {cout,sum} plus issue cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_bit_serial_adder;

  typedef struct packed {
    logic [8:0] res;
    int         issue;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic mon_en = 1'b0;
  logic rst_seen = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   busy8 = 0;
  int   busy2 = 0;
  logic [8:0] last8 = '0;
  logic [8:0] last2 = '0;
  exp_t q8[$];
  exp_t q2[$];

  logic [7:0] va[5] = '{8'h3C, 8'hFF, 8'hFF, 8'h80, 8'h00};
  logic [7:0] vb[5] = '{8'h5A, 8'h01, 8'hFF, 8'h80, 8'h00};
  logic       vc[5] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
  logic [8:0] vr[5] = '{9'h096, 9'h100, 9'h1FF, 9'h100, 9'h001};

  always #5 clk = ~clk;

  bit_serial_adder_if #(.WIDTH(8)) bus8 ();
  bit_serial_adder_if #(.WIDTH(2)) bus2 ();

  bit_serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  bit_serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  always @(posedge clk) begin
    cyc++;
    rst_seen = rst;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
    checks++;
    if (actual === required) passes++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
  endtask

  // Results must only move on a done pulse; everything else must hold
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (rst_seen) begin
        q8.delete();
        q2.delete();
        last8 = '0;
        last2 = '0;
        busy8 = 0;
        busy2 = 0;
      end
      if (bus8.busy) busy8++;
      if (bus2.busy) busy2++;
      if (bus8.done) begin
        check_output("dut8_done_expected", 32'(q8.size() != 0), 1);
        if (q8.size() != 0) begin
          e = q8.pop_front();
          check_output("dut8_result", {bus8.cout, bus8.sum}, e.res);
          check_output("dut8_latency", cyc - e.issue, 9);
          check_output("dut8_busy_cycles", busy8, 8);
          last8 = e.res;
        end
        busy8 = 0;
      end else begin
        check_output("dut8_hold", {bus8.cout, bus8.sum}, last8);
      end
      if (bus2.done) begin
        check_output("dut2_done_expected", 32'(q2.size() != 0), 1);
        if (q2.size() != 0) begin
          e = q2.pop_front();
          check_output("dut2_result", {bus2.cout, bus2.sum}, e.res);
          check_output("dut2_latency", cyc - e.issue, 3);
          check_output("dut2_busy_cycles", busy2, 2);
          last2 = e.res;
        end
        busy2 = 0;
      end else begin
        check_output("dut2_hold", {bus2.cout, bus2.sum}, last2);
      end
    end
  end

  task automatic wait_idle8();
    int n = 0;
    @(negedge clk);
    while (bus8.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_output("dut8_idle_timeout", 0, 1);
  endtask

  task automatic wait_idle2();
    int n = 0;
    @(negedge clk);
    while (bus2.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_output("dut2_idle_timeout", 0, 1);
  endtask

  task automatic apply_stimulus8(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic [8:0] res);
    wait_idle8();
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = cin;
    bus8.start = 1'b1;
    q8.push_back('{res: res, issue: cyc});
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic apply_stimulus2(input logic [1:0] a, input logic [1:0] b,
                                 input logic cin, input logic [8:0] res);
    wait_idle2();
    bus2.a     = a;
    bus2.b     = b;
    bus2.cin   = cin;
    bus2.start = 1'b1;
    q2.push_back('{res: res, issue: cyc});
    @(negedge clk);
    bus2.start = 1'b0;
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus8.cin   = 1'b0;
    bus2.start = 1'b0;
    bus2.a     = '0;
    bus2.b     = '0;
    bus2.cin   = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_busy8", bus8.busy, 0);
    check_output("reset_done8", bus8.done, 0);
    check_output("reset_sum8", {bus8.cout, bus8.sum}, 0);
    check_output("reset_sum2", {bus2.cout, bus2.sum}, 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) apply_stimulus8(va[i], vb[i], vc[i], vr[i]);

    // Start held high; operands change mid-RUN, second op accepted from DONE
    wait_idle8();
    bus8.a     = 8'h01;
    bus8.b     = 8'h02;
    bus8.cin   = 1'b0;
    bus8.start = 1'b1;
    q8.push_back('{res: 9'h003, issue: cyc});
    @(negedge clk);
    bus8.a = 8'h10;
    bus8.b = 8'h20;
    n = 0;
    while (!bus8.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_output("held_start_done_timeout", 0, 1);
    q8.push_back('{res: 9'h030, issue: cyc});
    @(negedge clk);
    bus8.start = 1'b0;

    // Abort mid-operation with reset
    apply_stimulus8(8'hAA, 8'h55, 1'b0, 9'h0FF);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("abort_busy8", bus8.busy, 0);
    check_output("abort_done8", bus8.done, 0);
    check_output("abort_sum8", bus8.sum, 0);
    check_output("abort_cout8", bus8.cout, 0);
    apply_stimulus8(8'h0F, 8'h0F, 1'b0, 9'h01E);

    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int c = 0; c < 2; c++)
          apply_stimulus2(2'(x), 2'(y), 1'(c), 9'(x + y + c));

    n = 0;
    while ((q8.size() != 0 || q2.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("drain_q8", q8.size(), 0);
    check_output("drain_q2", q2.size(), 0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
